// File: rtl/axi4_rd_arbiter_if.sv
// AXI4 read-address / read-data channel bundle.
// master drives AR and RREADY; slave drives ARREADY and R.
interface axi4_rd_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]   ARID;
    logic [ADDR_W-1:0] ARADDR;
    logic [7:0]        ARLEN;
    logic [2:0]        ARSIZE;
    logic [1:0]        ARBURST;
    logic              ARVALID;
    logic              ARREADY;
    logic [ID_W-1:0]   RID;
    logic [DATA_W-1:0] RDATA;
    logic [1:0]        RRESP;
    logic              RLAST;
    logic              RVALID;
    logic              RREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY
    );
endinterface

// File: rtl/axi4_rd_arbiter.sv
// Round-robin arbiter sharing one AXI4 read channel between the
// instruction-fetch and data-load requesters, one beat in flight.
module axi4_rd_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              inst_rd_en,
    input  logic [ADDR_W-1:0] inst_rd_addr,
    output logic              inst_rd_valid,
    output logic [DATA_W-1:0] inst_rd_data,
    output logic              inst_rd_err,
    input  logic              data_rd_en,
    input  logic [ADDR_W-1:0] data_rd_addr,
    input  logic [2:0]        data_rd_size,
    output logic              data_rd_valid,
    output logic [DATA_W-1:0] data_rd_data,
    output logic              data_rd_err,
    axi4_rd_arbiter_if.master axi
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic              last_grant;
    logic              owner;
    logic              inst_elig;
    logic              data_elig;
    logic              any_req;
    logic              win;
    logic              grant;
    logic              r_hs;
    logic              rsp_err;
    logic              arvalid;
    logic              rready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [2:0]        arsize;

    // A requester whose response is being delivered this cycle
    // still holds rd_en; masking it stops a duplicate issue.
    assign inst_elig = inst_rd_en && !inst_rd_valid;
    assign data_elig = data_rd_en && !data_rd_valid;
    assign any_req   = inst_elig || data_elig;
    assign win       = (inst_elig && data_elig) ? ~last_grant
                                                : data_elig;
    assign grant     = (state == IDLE) && any_req;
    assign r_hs      = (state == DATA) && axi.RVALID;
    assign rsp_err   = (axi.RRESP != 2'b00) || (axi.RID != arid)
                       || !axi.RLAST;

    // State register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state; AR/R handshake strobes decode from the state
    always_comb begin
        state_nx = state;
        arvalid  = 1'b0;
        rready   = 1'b0;
        unique case (state)
            IDLE: if (any_req) state_nx = ADDR;
            ADDR: begin
                arvalid = 1'b1;
                if (axi.ARREADY) state_nx = DATA;
            end
            DATA: begin
                rready = 1'b1;
                if (axi.RVALID) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Grant: remember the winner and latch its AR fields
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            last_grant <= 1'b1;
            owner      <= 1'b0;
            araddr     <= '0;
            arid       <= '0;
            arsize     <= '0;
        end else if (grant) begin
            last_grant <= win;
            owner      <= win;
            araddr     <= win ? data_rd_addr : inst_rd_addr;
            arid       <= win ? ID_W'(1) : '0;
            arsize     <= win ? data_rd_size : 3'b010;
        end
    end

    // Response: steer RDATA to the owner with a one-cycle valid
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            inst_rd_valid <= 1'b0;
            inst_rd_data  <= '0;
            inst_rd_err   <= 1'b0;
            data_rd_valid <= 1'b0;
            data_rd_data  <= '0;
            data_rd_err   <= 1'b0;
        end else begin
            inst_rd_valid <= 1'b0;
            inst_rd_err   <= 1'b0;
            data_rd_valid <= 1'b0;
            data_rd_err   <= 1'b0;
            if (r_hs && owner) begin
                data_rd_valid <= 1'b1;
                data_rd_data  <= axi.RDATA;
                data_rd_err   <= rsp_err;
            end else if (r_hs) begin
                inst_rd_valid <= 1'b1;
                inst_rd_data  <= axi.RDATA;
                inst_rd_err   <= rsp_err;
            end
        end
    end

    assign axi.ARID    = arid;
    assign axi.ARADDR  = araddr;
    assign axi.ARLEN   = 8'd0;
    assign axi.ARSIZE  = arsize;
    assign axi.ARBURST = 2'b01;
    assign axi.ARVALID = arvalid;
    assign axi.RREADY  = rready;
endmodule

// File: tb/tb_axi4_rd_arbiter.sv
// Self-checking bench for axi4_rd_arbiter: AXI slave model,
// requester tasks and a response scoreboard.
module tb_axi4_rd_arbiter;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int ID_W   = 4;

    typedef struct {
        logic        who;
        logic [31:0] data;
        logic        err;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [2:0]  size;
    } ar_t;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        inst_rd_en;
    logic [31:0] inst_rd_addr;
    logic        inst_rd_valid;
    logic [31:0] inst_rd_data;
    logic        inst_rd_err;
    logic        data_rd_en;
    logic [31:0] data_rd_addr;
    logic [2:0]  data_rd_size;
    logic        data_rd_valid;
    logic [31:0] data_rd_data;
    logic        data_rd_err;

    rsp_t rsp_q[$];
    ar_t  ar_q[$];
    int   errors = 0;
    int   checks = 0;

    int          ar_delay = 0;
    int          r_delay = 0;
    bit          ov_data_en = 0;
    logic [31:0] ov_data = '0;
    logic [1:0]  ov_resp = 2'b00;
    bit          ov_badid = 0;
    bit          ov_nolast = 0;
    bit          slave_busy = 0;

    always #5 ACLK = ~ACLK;

    axi4_rd_arbiter_if #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) axi ();

    axi4_rd_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .inst_rd_en    (inst_rd_en),
        .inst_rd_addr  (inst_rd_addr),
        .inst_rd_valid (inst_rd_valid),
        .inst_rd_data  (inst_rd_data),
        .inst_rd_err   (inst_rd_err),
        .data_rd_en    (data_rd_en),
        .data_rd_addr  (data_rd_addr),
        .data_rd_size  (data_rd_size),
        .data_rd_valid (data_rd_valid),
        .data_rd_data  (data_rd_data),
        .data_rd_err   (data_rd_err),
        .axi           (axi)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_5A5A;
    endfunction

    task automatic expect_ar(input logic [31:0] a,
                             input logic [3:0] id,
                             input logic [2:0] sz);
        ar_q.push_back('{addr: a, id: id, size: sz});
    endtask

    task automatic expect_rsp(input logic who,
                              input logic [31:0] d,
                              input logic e);
        rsp_q.push_back('{who: who, data: d, err: e});
    endtask

    task automatic take(input logic who,
                        input logic [31:0] d,
                        input logic e);
        rsp_t x;
        if (rsp_q.size() == 0) begin
            check("rsp_unexpected", {63'd0, who}, 64'd2);
        end else begin
            x = rsp_q.pop_front();
            check("rsp_who", who, x.who);
            check("rsp_data", d, x.data);
            check("rsp_err", e, x.err);
        end
    endtask

    // AXI slave model with programmable AR and R stalls
    initial begin
        ar_t got;
        ar_t ex;
        axi.ARREADY = 0;
        axi.RVALID = 0;
        axi.RID = '0;
        axi.RDATA = '0;
        axi.RRESP = '0;
        axi.RLAST = 0;
        forever begin
            @(negedge ACLK);
            if (ARESET || !axi.ARVALID) continue;
            slave_busy = 1;
            got.addr = axi.ARADDR;
            got.id = axi.ARID;
            got.size = axi.ARSIZE;
            if (ar_q.size() == 0) begin
                check("ar_unexpected", got.addr, 64'hFFFF_FFFF_FFFF);
            end else begin
                ex = ar_q.pop_front();
                check("araddr", got.addr, ex.addr);
                check("arid", got.id, ex.id);
                check("arsize", got.size, ex.size);
            end
            check("arlen", axi.ARLEN, 0);
            check("arburst", axi.ARBURST, 1);
            for (int i = 0; i < ar_delay; i++) begin
                @(negedge ACLK);
                check("arvalid_hold", axi.ARVALID, 1);
                check("araddr_hold", axi.ARADDR, got.addr);
            end
            axi.ARREADY = 1;
            @(posedge ACLK);
            #1 axi.ARREADY = 0;
            for (int i = 0; i < r_delay; i++) begin
                @(negedge ACLK);
                if (!ARESET) check("single_ar", axi.ARVALID, 0);
            end
            axi.RVALID = 1;
            axi.RDATA = ov_data_en ? ov_data : mem(got.addr);
            axi.RRESP = ov_resp;
            axi.RID = ov_badid ? (got.id ^ 4'h3) : got.id;
            axi.RLAST = !ov_nolast;
            @(posedge ACLK);
            #1;
            axi.RVALID = 0;
            axi.RLAST = 0;
            slave_busy = 0;
        end
    end

    // Response monitor: pops the scoreboard on every rd_valid
    initial begin
        forever begin
            @(negedge ACLK);
            if (ARESET) continue;
            if (inst_rd_valid && data_rd_valid)
                check("both_valid", 1, 0);
            if (inst_rd_valid)
                take(1'b0, inst_rd_data, inst_rd_err);
            if (data_rd_valid)
                take(1'b1, data_rd_data, data_rd_err);
        end
    end

    task automatic req_inst(input logic [31:0] a, input bit hold);
        int n;
        n = 0;
        inst_rd_addr = a;
        inst_rd_en = 1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!inst_rd_valid && n < 300);
        if (!inst_rd_valid) check("inst_timeout", 0, 1);
        if (!hold) begin
            @(posedge ACLK);
            #1 inst_rd_en = 0;
        end
    endtask

    task automatic req_data(input logic [31:0] a,
                            input logic [2:0] sz);
        int n;
        n = 0;
        data_rd_addr = a;
        data_rd_size = sz;
        data_rd_en = 1;
        do begin
            @(negedge ACLK);
            n++;
        end while (!data_rd_valid && n < 300);
        if (!data_rd_valid) check("data_timeout", 0, 1);
        @(posedge ACLK);
        #1 data_rd_en = 0;
    endtask

    task automatic gap();
        repeat (2) @(posedge ACLK);
        #1;
    endtask

    task automatic wait_slave();
        int n;
        n = 0;
        while (slave_busy && n < 100) begin
            @(posedge ACLK);
            n++;
        end
        if (slave_busy) check("slave_timeout", 0, 1);
        #1;
    endtask

    initial begin
        int n;
        inst_rd_en = 0;
        inst_rd_addr = '0;
        data_rd_en = 0;
        data_rd_addr = '0;
        data_rd_size = '0;
        repeat (3) @(posedge ACLK);
        #1;
        check("rst_arvalid", axi.ARVALID, 0);
        check("rst_rready", axi.RREADY, 0);
        check("rst_araddr", axi.ARADDR, 0);
        check("rst_arid", axi.ARID, 0);
        check("rst_arsize", axi.ARSIZE, 0);
        check("rst_ivalid", inst_rd_valid, 0);
        check("rst_dvalid", data_rd_valid, 0);
        check("rst_idata", inst_rd_data, 0);
        check("rst_ddata", data_rd_data, 0);
        check("rst_ierr", inst_rd_err, 0);
        check("rst_derr", data_rd_err, 0);

        // tie at reset exit: inst first, then data
        ARESET = 0;
        expect_ar(32'h100, 0, 3'd2);
        expect_ar(32'h200, 1, 3'd0);
        expect_rsp(0, mem(32'h100), 0);
        expect_rsp(1, mem(32'h200), 0);
        fork
            req_inst(32'h100, 0);
            req_data(32'h200, 3'd0);
        join
        gap();

        // tie after data won last: inst again
        expect_ar(32'h110, 0, 3'd2);
        expect_ar(32'h210, 1, 3'd1);
        expect_rsp(0, mem(32'h110), 0);
        expect_rsp(1, mem(32'h210), 0);
        fork
            req_inst(32'h110, 0);
            req_data(32'h210, 3'd1);
        join
        gap();

        // inst alone, then tie: data wins
        expect_ar(32'h300, 0, 3'd2);
        expect_rsp(0, mem(32'h300), 0);
        req_inst(32'h300, 0);
        gap();
        expect_ar(32'h400, 1, 3'd1);
        expect_ar(32'h500, 0, 3'd2);
        expect_rsp(1, mem(32'h400), 0);
        expect_rsp(0, mem(32'h500), 0);
        fork
            req_inst(32'h500, 0);
            req_data(32'h400, 3'd1);
        join
        gap();

        // minimum latency, cycle by cycle
        ov_data_en = 1;
        ov_data = 32'h0280_0000;
        expect_ar(32'h1C00_0000, 0, 3'd2);
        expect_rsp(0, 32'h0280_0000, 0);
        inst_rd_addr = 32'h1C00_0000;
        inst_rd_en = 1;
        @(posedge ACLK);
        #1;
        check("t1_arvalid", axi.ARVALID, 1);
        check("t1_araddr", axi.ARADDR, 32'h1C00_0000);
        check("t1_arid", axi.ARID, 0);
        check("t1_arsize", axi.ARSIZE, 2);
        check("t1_rready0", axi.RREADY, 0);
        @(posedge ACLK);
        #1;
        check("t1_arvalid_lo", axi.ARVALID, 0);
        check("t1_rready1", axi.RREADY, 1);
        @(posedge ACLK);
        #1;
        check("t1_valid", inst_rd_valid, 1);
        check("t1_data", inst_rd_data, 32'h0280_0000);
        check("t1_err", inst_rd_err, 0);
        check("t1_rready_lo", axi.RREADY, 0);
        inst_rd_en = 0;
        @(posedge ACLK);
        #1;
        check("t1_pulse", inst_rd_valid, 0);
        check("t1_idle", axi.ARVALID, 0);
        check("t1_hold", inst_rd_data, 32'h0280_0000);
        ov_data_en = 0;
        gap();

        // AR and R stalls
        ar_delay = 5;
        r_delay = 3;
        expect_ar(32'h600, 1, 3'd2);
        expect_rsp(1, mem(32'h600), 0);
        req_data(32'h600, 3'd2);
        ar_delay = 0;
        r_delay = 0;
        gap();

        // error responses still deliver data
        ov_data_en = 1;
        ov_data = 32'hDEAD_BEEF;
        ov_resp = 2'b10;
        expect_ar(32'h700, 1, 3'd2);
        expect_rsp(1, 32'hDEAD_BEEF, 1);
        req_data(32'h700, 3'd2);
        ov_data_en = 0;
        ov_resp = 2'b00;
        gap();
        ov_badid = 1;
        expect_ar(32'h710, 0, 3'd2);
        expect_rsp(0, mem(32'h710), 1);
        req_inst(32'h710, 0);
        ov_badid = 0;
        gap();
        ov_nolast = 1;
        expect_ar(32'h720, 1, 3'd0);
        expect_rsp(1, mem(32'h720), 1);
        req_data(32'h720, 3'd0);
        ov_nolast = 0;
        gap();

        // inst_rd_en held across completion
        expect_ar(32'h800, 0, 3'd2);
        expect_ar(32'h800, 0, 3'd2);
        expect_rsp(0, mem(32'h800), 0);
        expect_rsp(0, mem(32'h800), 0);
        req_inst(32'h800, 1);
        @(posedge ACLK);
        #1 check("no_dup_ar", axi.ARVALID, 0);
        @(posedge ACLK);
        #1 check("next_ar", axi.ARVALID, 1);
        req_inst(32'h800, 0);
        gap();

        // reset while waiting in DATA
        r_delay = 6;
        expect_ar(32'h900, 0, 3'd2);
        inst_rd_addr = 32'h900;
        inst_rd_en = 1;
        n = 0;
        do begin
            @(negedge ACLK);
            n++;
        end while (!axi.RREADY && n < 50);
        check("t6_reach_data", axi.RREADY, 1);
        #1 ARESET = 1;
        #1;
        check("t6_rready", axi.RREADY, 0);
        check("t6_arvalid", axi.ARVALID, 0);
        check("t6_araddr", axi.ARADDR, 0);
        check("t6_ivalid", inst_rd_valid, 0);
        check("t6_idata", inst_rd_data, 0);
        check("t6_ddata", data_rd_data, 0);
        inst_rd_en = 0;
        @(posedge ACLK);
        #1 ARESET = 0;
        wait_slave();
        r_delay = 0;
        gap();
        expect_ar(32'hA00, 0, 3'd2);
        expect_rsp(0, mem(32'hA00), 0);
        req_inst(32'hA00, 0);

        repeat (5) @(posedge ACLK);
        #1;
        check("rsp_q_empty", rsp_q.size(), 0);
        check("ar_q_empty", ar_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/axi4_rd_arbiter.md
# axi4_rd_arbiter

Shares the single AXI4 read-address/read-data channel pair between the instruction-fetch and data-load SRAM-style read requesters. Round-robin arbitration, one outstanding single-beat transaction at a time. The granted request is registered onto AR and RDATA is returned to the winner with a one-cycle valid pulse. Sits between the core's inst/data read ports and the AXI4 master port toward the interconnect.

## Interface
- ADDR_W, 32, address width of requesters and ARADDR
- DATA_W, 32, data width of requesters and RDATA
- ID_W, 4, width of ARID/RID
- ACLK  in  1  clock; all state updates on rising edge
- ARESET  in  1  reset, asynchronous assert, active-high
- inst_rd_en  in  1  instruction read request, held until inst_rd_valid
- inst_rd_addr  in  ADDR_W  instruction read address
- inst_rd_valid  out  1  one-cycle pulse: inst_rd_data valid
- inst_rd_data  out  DATA_W  returned instruction word
- inst_rd_err  out  1  with inst_rd_valid: RRESP != OKAY or RID mismatch
- data_rd_en  in  1  data read request, held until data_rd_valid
- data_rd_addr  in  ADDR_W  data read address
- data_rd_size  in  3  AXI size encoding for the data read
- data_rd_valid, data_rd_data, data_rd_err  out  1/DATA_W/1  as for inst
- ARID  out  ID_W;  ARADDR  out  ADDR_W;  ARLEN  out  8;  ARSIZE  out  3;  ARBURST  out  2
- ARVALID  out  1;  ARREADY  in  1
- RID  in  ID_W;  RDATA  in  DATA_W;  RRESP  in  2;  RLAST  in  1;  RVALID  in  1;  RREADY  out  1
- ARLOCK/ARCACHE/ARPROT/ARQOS/ARREGION are not ports; tied zero at the top level.

## Operation
- States: IDLE, ADDR, DATA. Register last_grant (0 = inst, 1 = data).
- IDLE: if any eligible request, pick winner, latch ARADDR/ARSIZE/ARID, set ARVALID=1, go ADDR.
- Winner: only one requesting -> that one; both -> the one not equal to last_grant; update last_grant to winner.
- Eligibility: a requester is ineligible in the cycle its own rd_valid is high (prevents re-issue of the just-completed request).
- Fields: ARLEN=0, ARBURST=2'b01 constant. inst: ARID=0, ARSIZE=3'b010. data: ARID=1, ARSIZE=data_rd_size.
- ADDR: ARVALID high, ARADDR/ARID/ARSIZE stable. On ARVALID&&ARREADY: ARVALID<=0, RREADY<=1, go DATA.
- DATA: on RVALID&&RREADY: capture RDATA into winner's rd_data, pulse winner's rd_valid next cycle, RREADY<=0, go IDLE.
- err = (RRESP != 2'b00) || (RID != latched ARID) || !RLAST; data still delivered.
- RVALID outside DATA: RREADY low, ignored.
- rd_en deassert after grant: transaction still completes on AXI; rd_valid still pulsed.
- rd_data holds its value until next completion for that requester.

## Timing
- Reset (async, any state): state IDLE, last_grant=1 (inst wins first tie), ARVALID=0, RREADY=0, ARADDR=0, ARID=0, ARSIZE=0, all rd_valid/rd_err=0, all rd_data=0. Mid-transaction reset abandons it; no response delivered.
- Request sampled high at edge N -> ARVALID high from N+1.
- ARREADY high in the first ARVALID cycle -> RREADY high from N+2.
- RVALID in the first RREADY cycle -> rd_valid/rd_data/rd_err at N+3. Minimum latency 3 cycles.
- Back-to-back: next grant sampled at N+3; its ARVALID rises at N+4.
- ARREADY/RVALID stalls extend ADDR/DATA indefinitely; no timeout.
- Never more than one AR outstanding; rd_valid never high for both requesters in the same cycle.

## Test plan
- Single inst read of 0x1C000000, ARREADY/RVALID immediate, RDATA=0x02800000 -> ARID=0, ARSIZE=2, inst_rd_valid one cycle at N+3, inst_rd_data=0x02800000, err=0.
- Both request at reset exit (inst 0x100, data 0x200 size 0) -> inst AR first, then data AR with ARID=1, ARSIZE=0; next tie again -> inst (alternates).
- ARREADY held low 5 cycles, RVALID 3 cycles late -> ARVALID/ARADDR stable throughout, single rd_valid pulse, no second AR issued.
- RRESP=2'b10 on a data read, RDATA=0xDEADBEEF -> data_rd_valid=1, data_rd_err=1, data_rd_data=0xDEADBEEF.
- inst_rd_en held continuously across completion -> no duplicate AR in the rd_valid cycle; next AR only on the following IDLE sample.
- ARESET asserted while in DATA -> outputs immediately to reset values, no rd_valid; a later request completes normally.
